// File: rtl/image_processor.sv
// image_processor: counts red and blue RGB332 pixels inside the active window
// and issues a RED / BLUE / NONE decision once per frame.
// Latency: RESULT_VALID pulses on the edge after the DECIDE cycle, i.e. one
// cycle after the edge that sampled pixel (SCREEN_WIDTH-1, SCREEN_HEIGHT-1).
// Backpressure: none; pixels are taken whenever PIXEL_VALID is high.
//
// Ports:
//   CLOCK, RESET            single clock, asynchronous active-high reset
//   PIXEL_IN[7:0]           RGB332 pixel, R=[7:5] G=[4:2] B=[1:0]
//   PIXEL_VALID             PIXEL_IN / VGA_PIXEL_X / VGA_PIXEL_Y are valid
//   VGA_PIXEL_X/Y[9:0]      column / row of PIXEL_IN
//   RESULT[1:0]             00 NONE, 01 RED, 10 BLUE (held between frames)
//   RESULT_VALID            one-cycle pulse per completed frame
//   BUSY                    high while accumulating a frame
//   RED_COUNT/BLUE_COUNT    counts of the last completed frame
//
// Optional feature: define IP_HISTORY_EN to update RESULT only when a frame's
// decision matches the previous frame's decision.
module image_processor #(
  parameter int          SCREEN_WIDTH  = 176,
  parameter int          SCREEN_HEIGHT = 120,
  parameter logic [14:0] THRESHOLD     = 15'd2000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [7:0]  PIXEL_IN,
  input  logic        PIXEL_VALID,
  input  logic [9:0]  VGA_PIXEL_X,
  input  logic [9:0]  VGA_PIXEL_Y,
  output logic [1:0]  RESULT,
  output logic        RESULT_VALID,
  output logic        BUSY,
  output logic [14:0] RED_COUNT,
  output logic [14:0] BLUE_COUNT
);

  localparam logic [9:0]  X_LIM   = 10'(SCREEN_WIDTH);
  localparam logic [9:0]  Y_LIM   = 10'(SCREEN_HEIGHT);
  localparam logic [9:0]  X_LAST  = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0]  Y_LAST  = 10'(SCREEN_HEIGHT - 1);
  localparam logic [14:0] CNT_MAX = 15'h7FFF;

  localparam logic [1:0] DEC_NONE = 2'b00;
  localparam logic [1:0] DEC_RED  = 2'b01;
  localparam logic [1:0] DEC_BLUE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [14:0] red_cnt, red_nxt;
  logic [14:0] blue_cnt, blue_nxt;
  logic [1:0]  result_nxt;
  logic        valid_nxt;
  logic [14:0] red_out_nxt, blue_out_nxt;
  logic [1:0]  decision;

  logic [2:0] pix_r, pix_g;
  logic [1:0] pix_b;
  logic       in_window, at_origin, at_last;
  logic       is_red, is_blue;
  logic [14:0] red_inc, blue_inc;

  assign pix_r = PIXEL_IN[7:5];
  assign pix_g = PIXEL_IN[4:2];
  assign pix_b = PIXEL_IN[1:0];

  assign in_window = PIXEL_VALID && (VGA_PIXEL_X < X_LIM) && (VGA_PIXEL_Y < Y_LIM);
  assign at_origin = (VGA_PIXEL_X == 10'd0) && (VGA_PIXEL_Y == 10'd0);
  assign at_last   = (VGA_PIXEL_X == X_LAST) && (VGA_PIXEL_Y == Y_LAST);

  // The two classes are disjoint: red needs B<=1, blue needs B==3.
  assign is_red  = (pix_r >= 3'd5) && (pix_g <= 3'd2) && (pix_b <= 2'd1);
  assign is_blue = (pix_b == 2'd3) && (pix_r <= 3'd2) && (pix_g <= 3'd2);

  assign red_inc  = (red_cnt  == CNT_MAX) ? red_cnt  : red_cnt  + 15'd1;
  assign blue_inc = (blue_cnt == CNT_MAX) ? blue_cnt : blue_cnt + 15'd1;

  // Equal counts fall through to NONE because both strict comparisons fail.
  always_comb begin
    decision = DEC_NONE;
    if ((red_cnt >= THRESHOLD) && (red_cnt > blue_cnt)) begin
      decision = DEC_RED;
    end else if ((blue_cnt >= THRESHOLD) && (blue_cnt > red_cnt)) begin
      decision = DEC_BLUE;
    end
  end

`ifdef IP_HISTORY_EN
  logic [1:0] hist, hist_nxt;
`endif

  always_comb begin
    state_nxt    = state;
    red_nxt      = red_cnt;
    blue_nxt     = blue_cnt;
    result_nxt   = RESULT;
    valid_nxt    = 1'b0;
    red_out_nxt  = RED_COUNT;
    blue_out_nxt = BLUE_COUNT;
`ifdef IP_HISTORY_EN
    hist_nxt     = hist;
`endif
    case (state)
      IDLE: begin
        if (in_window && at_origin) begin
          red_nxt   = {14'd0, is_red};
          blue_nxt  = {14'd0, is_blue};
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (in_window) begin
          if (at_origin) begin
            // A new origin pixel abandons the current frame and starts over.
            red_nxt  = {14'd0, is_red};
            blue_nxt = {14'd0, is_blue};
          end else begin
            if (is_red)  red_nxt  = red_inc;
            if (is_blue) blue_nxt = blue_inc;
            if (at_last) state_nxt = DECIDE;
          end
        end
      end
      DECIDE: begin
        state_nxt    = IDLE;
        valid_nxt    = 1'b1;
        red_out_nxt  = red_cnt;
        blue_out_nxt = blue_cnt;
        red_nxt      = 15'd0;
        blue_nxt     = 15'd0;
`ifdef IP_HISTORY_EN
        if (decision == hist) result_nxt = decision;
        hist_nxt = decision;
`else
        result_nxt = decision;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      red_cnt      <= 15'd0;
      blue_cnt     <= 15'd0;
      RESULT       <= DEC_NONE;
      RESULT_VALID <= 1'b0;
      RED_COUNT    <= 15'd0;
      BLUE_COUNT   <= 15'd0;
    end else begin
      state        <= state_nxt;
      red_cnt      <= red_nxt;
      blue_cnt     <= blue_nxt;
      RESULT       <= result_nxt;
      RESULT_VALID <= valid_nxt;
      RED_COUNT    <= red_out_nxt;
      BLUE_COUNT   <= blue_out_nxt;
    end
  end

`ifdef IP_HISTORY_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) hist <= DEC_NONE;
    else       hist <= hist_nxt;
  end
`endif

  assign BUSY = (state == ACCUM);

endmodule

// File: doc/image_processor.md
IMAGE_PROCESSOR -- requirements
Module: image_processor

Interface
REQ-001 Parameter SCREEN_WIDTH, default 176: active window width in pixels.
REQ-002 Parameter SCREEN_HEIGHT, default 120: active window height in pixels.
REQ-003 Parameter THRESHOLD, default 15'd2000: minimum per-colour pixel count for a colour decision.
REQ-004 CLOCK  input  1: the single clock; all state changes on its rising edge.
REQ-005 RESET  input  1: asynchronous, active-high reset.
REQ-006 PIXEL_IN  input  8: RGB332 pixel read from the frame buffer, with R=[7:5], G=[4:2], B=[1:0].
REQ-007 PIXEL_VALID  input  1: PIXEL_IN, VGA_PIXEL_X and VGA_PIXEL_Y are sampled on this cycle.
REQ-008 VGA_PIXEL_X  input  10: column of PIXEL_IN.
REQ-009 VGA_PIXEL_Y  input  10: row of PIXEL_IN.
REQ-010 RESULT  output  2: current decision, with 2'b00 NONE, 2'b01 RED, 2'b10 BLUE; 2'b11 is never driven.
REQ-011 RESULT_VALID  output  1: one-cycle pulse marking the end of a frame decision.
REQ-012 BUSY  output  1: high while in state ACCUM.
REQ-013 RED_COUNT  output  15: red count registered from the last completed frame.
REQ-014 BLUE_COUNT  output  15: blue count registered from the last completed frame.

Function
REQ-015 The block SHALL treat a pixel as in-window only when PIXEL_VALID=1, VGA_PIXEL_X<SCREEN_WIDTH and VGA_PIXEL_Y<SCREEN_HEIGHT; all other pixels SHALL be ignored.
REQ-016 The block SHALL classify a pixel as red when R>=5, G<=2 and B<=1.
REQ-017 The block SHALL classify a pixel as blue when B==3, R<=2 and G<=2.
REQ-018 A pixel SHALL never be classified as both red and blue.
REQ-019 The FSM SHALL have the states IDLE, ACCUM and DECIDE.
REQ-020 In IDLE, an in-window pixel at (0,0) SHALL load the internal red and blue counters with that pixel's classification and move to ACCUM; other pixels SHALL be ignored.
REQ-021 In ACCUM, each in-window pixel SHALL increment the internal red or blue counter by 1 according to its class.
REQ-022 The internal red and blue counters SHALL saturate at 15'h7FFF.
REQ-023 In ACCUM, an in-window pixel at (0,0) SHALL restart the frame: the counters reload from that pixel and the state stays ACCUM, with no decision made.
REQ-024 In ACCUM, the in-window pixel at (SCREEN_WIDTH-1,SCREEN_HEIGHT-1) SHALL be counted and SHALL move the state to DECIDE on the same edge.
REQ-025 DECIDE SHALL last exactly one cycle and then return to IDLE; PIXEL_VALID SHALL be ignored during DECIDE.
REQ-026 On the edge leaving DECIDE, the block SHALL register RED_COUNT and BLUE_COUNT, update RESULT, assert RESULT_VALID for one cycle and clear the internal counters.
REQ-027 RESULT_VALID SHALL therefore be high in the cycle after the one in which the last pixel was sampled, giving a latency of one cycle.
REQ-028 The frame decision SHALL be RED if red>=THRESHOLD and red>blue.
REQ-029 The frame decision SHALL be BLUE if blue>=THRESHOLD and blue>red.
REQ-030 In all other cases, including equal counts, the frame decision SHALL be NONE.
REQ-031 RESULT SHALL hold its value between decisions.
REQ-032 All comparisons SHALL be unsigned, 15-bit.

Reset
REQ-033 Asserting RESET SHALL, asynchronously, force the state to IDLE.
REQ-034 Asserting RESET SHALL, asynchronously, force RESULT=2'b00, RESULT_VALID=0, BUSY=0, RED_COUNT=0 and BLUE_COUNT=0.
REQ-035 Asserting RESET SHALL, asynchronously, clear the internal counters and the history register.
REQ-036 A reset in ACCUM or DECIDE SHALL discard the partial frame, and no RESULT_VALID SHALL be produced for that frame.
REQ-037 After RESET deasserts, the block SHALL wait for the next (0,0) pixel before counting.

Configuration
REQ-038 Macro IP_HISTORY_EN, when defined, SHALL make RESULT update only when the current frame decision equals the previous frame's decision, which is held in a 2-bit history register reset to NONE.
REQ-039 With IP_HISTORY_EN defined, RESULT_VALID SHALL still pulse every completed frame.
REQ-040 With IP_HISTORY_EN undefined, RESULT SHALL take each frame's decision directly and no history register SHALL exist.

Verification
REQ-041 A full 176x120 frame, all pixels 8'b111_000_00 -> RED_COUNT=21120, BLUE_COUNT=0, RESULT=01, one RESULT_VALID pulse one cycle after pixel (175,119).
REQ-042 A frame with 1999 blue pixels (8'b000_000_11) and the rest white -> BLUE_COUNT=1999, RESULT=00.
REQ-043 Repeating REQ-042 with 2000 blue pixels -> RESULT=10.
REQ-044 A frame of 3000 red and 3000 blue pixels -> RESULT=00, both counts 3000.
REQ-045 Restart at pixel (50,60) by a new (0,0) pixel, then a full blue frame -> exactly one RESULT_VALID, BLUE_COUNT=21120.
REQ-046 Pixels at x=176..639 or y>=120 interleaved with a red frame -> counts unaffected.
REQ-047 RESET asserted mid-ACCUM -> all outputs zero immediately and no pulse.
REQ-048 With IP_HISTORY_EN, red then blue then blue frames -> RESULT sequence 00, 00, 10.
